// File: rtl/uart_tx_frame.sv
// uart_tx_frame
// Parametrised UART transmitter: one character per frame with a 5..DBIT_MAX bit
// data field, optional even/odd parity and a 1, 1.5 or 2 bit stop field. Bit
// timing comes from the shared oversampling strobe s_tick (OVS strobes per bit).
// A one-entry holding register behind tx_valid/tx_ready lets a second character
// wait while a frame is on the line, so frames can follow with no idle gap.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high
//   s_tick      single-cycle baud oversampling strobe
//   tx_valid    a character is offered on tx_data
//   tx_ready    holding register is free
//   tx_data     character; bits above the active length are ignored
//   cfg_dbits   data bits per frame (clamped to 5..DBIT_MAX)
//   cfg_parity  00 none, 01 even, 10 odd, 11 none
//   cfg_stop    00 one, 01 one-and-a-half, 10/11 two stop bits
//   tx          serial line, idle high, registered
//   tx_busy     frame engine not IDLE, registered
//   tx_done     one-cycle pulse when a frame's stop field completes
//   dbg_state   current frame engine state (IDLE=0 START=1 DATA=2 PARITY=3 STOP=4)
//
// Handshake: a beat transfers on a rising clk edge where tx_valid && tx_ready;
// tx_valid may be raised at any time and tx_ready (= holding register empty)
// does not depend on tx_valid in the same cycle.

module uart_tx_frame #(
  parameter int DBIT_MAX = 8,
  parameter int OVS      = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_tick,
  input  logic                tx_valid,
  output logic                tx_ready,
  input  logic [DBIT_MAX-1:0] tx_data,
  input  logic [3:0]          cfg_dbits,
  input  logic [1:0]          cfg_parity,
  input  logic [1:0]          cfg_stop,
  output logic                tx,
  output logic                tx_busy,
  output logic                tx_done,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Tick counter must reach 2*OVS-1 for a two-bit stop field.
  localparam int TW = $clog2(2 * OVS);
  localparam logic [TW-1:0] T_BIT    = TW'(OVS - 1);
  localparam logic [TW-1:0] T_STOP1  = TW'(OVS - 1);
  localparam logic [TW-1:0] T_STOP15 = TW'((3 * OVS) / 2 - 1);
  localparam logic [TW-1:0] T_STOP2  = TW'(2 * OVS - 1);
  localparam logic [3:0]    DMAX     = 4'(DBIT_MAX);

  state_t                state, state_n;
  logic [TW-1:0]         tick_cnt, tick_n;
  logic [3:0]            bit_cnt, bit_n;
  logic [DBIT_MAX-1:0]   shift, shift_n;
  logic [3:0]            dbits_l, dbits_n;
  logic                  par_en, par_en_n;
  logic                  par_bit, par_bit_n;
  logic [TW-1:0]         stop_last, stop_last_n;
  logic                  hold_full, hold_full_n;
  logic [DBIT_MAX-1:0]   hold_data, hold_data_n;
  logic                  tx_n, busy_n, done_n;

  // Load-side decode of the frame that would start this cycle.
  logic                  accept, avail, load;
  logic [DBIT_MAX-1:0]   load_data, masked;
  logic [3:0]            cfg_d;
  logic                  load_par_en, load_par_bit;
  logic [TW-1:0]         load_stop_last;

  assign tx_ready  = !hold_full;
  assign dbg_state = state;

  always_comb begin
    accept    = tx_valid && !hold_full;
    // With the hold register empty a frame is available only through bypass.
    avail     = hold_full || tx_valid;
    load_data = hold_full ? hold_data : tx_data;

    if (cfg_dbits < 4'd5)       cfg_d = 4'd5;
    else if (cfg_dbits > DMAX)  cfg_d = DMAX;
    else                        cfg_d = cfg_dbits;

    masked = '0;
    for (int i = 0; i < DBIT_MAX; i++) begin
      if (i < int'(cfg_d)) masked[i] = load_data[i];
    end

    load_par_en  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
    load_par_bit = (^masked) ^ (cfg_parity == 2'b10);

    case (cfg_stop)
      2'b00:   load_stop_last = T_STOP1;
      2'b01:   load_stop_last = T_STOP15;
      default: load_stop_last = T_STOP2;
    endcase
  end

  always_comb begin
    state_n     = state;
    tick_n      = tick_cnt;
    bit_n       = bit_cnt;
    shift_n     = shift;
    dbits_n     = dbits_l;
    par_en_n    = par_en;
    par_bit_n   = par_bit;
    stop_last_n = stop_last;
    hold_full_n = hold_full;
    hold_data_n = hold_data;
    done_n      = 1'b0;
    load        = 1'b0;

    case (state)
      IDLE: begin
        if (avail) load = 1'b1;
      end
      START: begin
        if (s_tick) begin
          if (tick_cnt == T_BIT) begin
            tick_n  = '0;
            state_n = DATA;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (tick_cnt == T_BIT) begin
            tick_n  = '0;
            shift_n = shift >> 1;
            if (bit_cnt == dbits_l - 4'd1) begin
              bit_n   = '0;
              state_n = par_en ? PARITY : STOP;
            end else begin
              bit_n = bit_cnt + 4'd1;
            end
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (tick_cnt == T_BIT) begin
            tick_n  = '0;
            state_n = STOP;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (tick_cnt == stop_last) begin
            tick_n = '0;
            done_n = 1'b1;
            if (avail) load = 1'b1;
            else       state_n = IDLE;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // A load restarts all counters; the tick on the load edge is not counted.
    if (load) begin
      state_n     = START;
      tick_n      = '0;
      bit_n       = '0;
      shift_n     = masked;
      dbits_n     = cfg_d;
      par_en_n    = load_par_en;
      par_bit_n   = load_par_bit;
      stop_last_n = load_stop_last;
    end

    if (load && hold_full) begin
      hold_full_n = 1'b0;
    end else if (accept && !load) begin
      hold_full_n = 1'b1;
      hold_data_n = tx_data;
    end

    // Line level follows the next state so tx is a plain register output.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      PARITY:  tx_n = par_bit_n;
      default: tx_n = 1'b1;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      dbits_l   <= 4'd5;
      par_en    <= 1'b0;
      par_bit   <= 1'b0;
      stop_last <= T_STOP1;
      hold_full <= 1'b0;
      hold_data <= '0;
      tx        <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_n;
      tick_cnt  <= tick_n;
      bit_cnt   <= bit_n;
      shift     <= shift_n;
      dbits_l   <= dbits_n;
      par_en    <= par_en_n;
      par_bit   <= par_bit_n;
      stop_last <= stop_last_n;
      hold_full <= hold_full_n;
      hold_data <= hold_data_n;
      tx        <= tx_n;
      tx_busy   <= busy_n;
      tx_done   <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: directed frames from the test plan, back-to-back and
// mid-frame reset cases, then randomized characters/configurations. Expected
// frames are queued at acceptance; a monitor rebuilds each frame tick by tick
// from the line and checks it when tx_done pulses.

module tb_uart_tx_frame;

  localparam int DBIT_MAX = 8;
  localparam int OVS      = 16;
  localparam int EW       = 32;
  localparam int LIM      = 5000;

  logic                clk;
  logic                reset;
  logic                s_tick;
  logic                tx_valid;
  logic                tx_ready;
  logic [DBIT_MAX-1:0] tx_data;
  logic [3:0]          cfg_dbits;
  logic [1:0]          cfg_parity;
  logic [1:0]          cfg_stop;
  logic                tx;
  logic                tx_busy;
  logic                tx_done;
  logic [2:0]          dbg_state;

  int total;
  int bad;
  int tick_mode;
  int frames_done;
  int busy_drops;
  logic prev_busy;

  // Expected frame word: [31:24] stop ticks, [23:16] bit periods, [15:0] levels.
  logic [EW-1:0] exp_q[$];
  logic          got_q[$];

  uart_tx_frame #(.DBIT_MAX(DBIT_MAX), .OVS(OVS)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_tick     (s_tick),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .cfg_dbits  (cfg_dbits),
    .cfg_parity (cfg_parity),
    .cfg_stop   (cfg_stop),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .dbg_state  (dbg_state)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud strobe: every 4th clock, or random (consecutive strobes possible).
  initial begin
    int div;
    div    = 0;
    s_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_mode == 0) begin
        div    = (div == 3) ? 0 : div + 1;
        s_tick = (div == 3);
      end else begin
        s_tick = ($urandom_range(0, 2) == 0);
      end
    end
  end

  // Reference model: a frame is a list of bit periods (start, data LSB first,
  // optional parity) each OVS ticks long, followed by the high stop field.
  function automatic logic [EW-1:0] model(input logic [7:0] d, input logic [3:0] db,
                                          input logic [1:0] par, input logic [1:0] st);
    int n;
    int np;
    int stk;
    logic p;
    logic [15:0] lv;
    n  = (db < 5) ? 5 : ((int'(db) > DBIT_MAX) ? DBIT_MAX : int'(db));
    lv = '0;
    p  = 1'b0;
    for (int i = 0; i < n; i++) begin
      lv[i+1] = d[i];
      p       = p ^ d[i];
    end
    np = 1 + n;
    if (par == 2'b01 || par == 2'b10) begin
      lv[np] = (par == 2'b10) ? ~p : p;
      np     = np + 1;
    end
    stk = (st == 2'b00) ? OVS : ((st == 2'b01) ? (OVS * 3) / 2 : 2 * OVS);
    return {stk[7:0], np[7:0], lv};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [EW-1:0] e;
    int np;
    int stk;
    int len;
    int first_bad;
    logic lvl;
    if (reset) begin
      got_q.delete();
      prev_busy = 1'b0;
    end else begin
      if (tx_done) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: got a frame of %0d ticks, expected none", got_q.size());
        end else begin
          e   = exp_q.pop_front();
          stk = int'(e[31:24]);
          np  = int'(e[23:16]);
          len = np * OVS + stk;
          total++;
          if (got_q.size() != len) begin
            bad++;
            $display("FAIL frame_len: got=%0d ticks expected=%0d", got_q.size(), len);
          end
          first_bad = -1;
          for (int k = 0; k < got_q.size(); k++) begin
            lvl = (k < np * OVS) ? e[k / OVS] : 1'b1;
            if (got_q[k] !== lvl && first_bad < 0) first_bad = k;
          end
          total++;
          if (first_bad >= 0) begin
            bad++;
            $display("FAIL frame_bits: tick %0d got=%b expected=%b (frame %0h)",
                     first_bad, got_q[first_bad], e[first_bad / OVS], e);
          end
          frames_done++;
        end
        got_q.delete();
      end
      if (!tx_busy) begin
        total++;
        if (tx !== 1'b1) begin
          bad++;
          $display("FAIL idle_line: got tx=%b expected 1", tx);
        end
      end
      if (prev_busy && !tx_busy) busy_drops++;
      prev_busy = tx_busy;
      if (s_tick && tx_busy) got_q.push_back(tx);
    end
  end

  // Offer one character; returns once it is loaded into the frame engine.
  task automatic send(input logic [7:0] d, input logic [3:0] db, input logic [1:0] par,
                      input logic [1:0] st, output logic held);
    int cyc;
    tx_data    = d;
    cfg_dbits  = db;
    cfg_parity = par;
    cfg_stop   = st;
    tx_valid   = 1'b1;
    cyc = 0;
    while (tx_ready !== 1'b1 && cyc < LIM) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("accept_wait", 32'(cyc < LIM), 32'd1);
    exp_q.push_back(model(d, db, par, st));
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    held     = !tx_ready;
    cyc = 0;
    while (tx_ready !== 1'b1 && cyc < LIM) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("load_wait", 32'(cyc < LIM), 32'd1);
    // Loaded: config/data inputs no longer matter to this frame.
    tx_data    = 8'($urandom);
    cfg_dbits  = 4'($urandom_range(0, 15));
    cfg_parity = 2'($urandom_range(0, 3));
    cfg_stop   = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || tx_busy) && cyc < LIM) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("drain_wait", 32'(cyc < LIM), 32'd1);
  endtask

  initial begin
    logic held;
    int drops0;
    int done0;
    int cyc;
    total       = 0;
    bad         = 0;
    tick_mode   = 0;
    frames_done = 0;
    busy_drops  = 0;
    prev_busy   = 1'b0;
    tx_valid    = 1'b0;
    tx_data     = '0;
    cfg_dbits   = 4'd8;
    cfg_parity  = 2'b00;
    cfg_stop    = 2'b00;
    reset       = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_ready", 32'(tx_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) begin @(posedge clk); #1; end

    // 8N1 0xA5; line and busy change on the accepting edge
    send(8'hA5, 4'd8, 2'b00, 2'b00, held);
    check("accept_tx_low", 32'(tx), 32'd0);
    check("accept_busy", 32'(tx_busy), 32'd1);
    check("accept_not_held", 32'(held), 32'd0);
    wait_idle();
    // 7E1 / 7O1 0xB5, 5O2 0x1F, 8N1.5 0x00
    send(8'hB5, 4'd7, 2'b01, 2'b00, held); wait_idle();
    send(8'hB5, 4'd7, 2'b10, 2'b00, held); wait_idle();
    send(8'h1F, 4'd5, 2'b10, 2'b10, held); wait_idle();
    send(8'h00, 4'd8, 2'b00, 2'b01, held); wait_idle();

    // Back-to-back: second beat waits in the hold register, no idle gap
    drops0 = busy_drops;
    done0  = frames_done;
    send(8'h55, 4'd8, 2'b00, 2'b00, held);
    check("b2b_first_bypass", 32'(held), 32'd0);
    send(8'hAA, 4'd8, 2'b00, 2'b00, held);
    check("b2b_second_held", 32'(held), 32'd1);
    wait_idle();
    check("b2b_busy_drops", 32'(busy_drops - drops0), 32'd1);
    check("b2b_frames", 32'(frames_done - done0), 32'd2);

    // Length clamping and parity/stop code 11
    send(8'hE7, 4'd2, 2'b01, 2'b11, held); wait_idle();
    send(8'h3C, 4'd15, 2'b11, 2'b01, held); wait_idle();

    // Reset during DATA with a character held
    send(8'h3C, 4'd8, 2'b00, 2'b00, held);
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    check("hold_ready_low", 32'(tx_ready), 32'd0);
    cyc = 0;
    while (dbg_state != 3'd2 && cyc < LIM) begin @(posedge clk); #1; cyc++; end
    check("reach_data", 32'(cyc < LIM), 32'd1);
    repeat (10) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    exp_q.delete();
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_busy", 32'(tx_busy), 32'd0);
    check("mid_rst_ready", 32'(tx_ready), 32'd1);
    check("mid_rst_done", 32'(tx_done), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    send(8'h81, 4'd8, 2'b00, 2'b00, held);
    wait_idle();

    // Randomized characters, configurations, gaps and strobe timing
    tick_mode = 1;
    repeat (24) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send(8'($urandom), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), held);
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter. It serialises one character per frame with a configurable data length (5..DBIT_MAX), parity (none/even/odd) and stop length (1, 1.5 or 2 bits). It sits between the result formatter and the serial pin, and shares the oversampling baud tick with the receiver. A one-entry holding register behind a valid/ready handshake allows back-to-back frames with zero idle gap.

## Interface
- DBIT_MAX, 8, widest data field and width of tx_data; legal range 5..9
- OVS, 16, s_tick pulses per bit period; must be even and at least 4
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- s_tick  in  1  single-cycle baud oversampling strobe
- tx_valid  in  1  a character is offered on tx_data
- tx_ready  out  1  holding register free; a beat is accepted when tx_valid && tx_ready
- tx_data  in  DBIT_MAX  character; bits above the active length are ignored
- cfg_dbits  in  4  data bits per frame; values below 5 are treated as 5, values above DBIT_MAX as DBIT_MAX
- cfg_parity  in  2  00 none, 01 even, 10 odd, 11 treated as none
- cfg_stop  in  2  00 one stop bit, 01 one-and-a-half, 10 two, 11 treated as two
- tx  out  1  serial line; idle high
- tx_busy  out  1  frame engine not IDLE
- tx_done  out  1  one-cycle pulse when a frame's stop field completes

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Frame load:
  - Source priority is the hold register first, else a beat accepted in the same cycle (bypass).
  - On load, latch the data into the shift register and latch cfg_dbits, cfg_parity and cfg_stop.
  - Config changes mid-frame have no effect on the frame in progress.
- START: tx=0 for OVS ticks, then DATA.
- DATA:
  - tx = shift[0], LSB first.
  - After each OVS ticks, shift right and increment the bit counter.
  - After the latched dbits bits, go to PARITY if parity is enabled, else STOP.
- PARITY:
  - tx = XOR of the active data bits (even), or its inverse (odd).
  - Lasts OVS ticks, then STOP.
- STOP:
  - tx=1 for OVS, 3*OVS/2 or 2*OVS ticks.
  - On the final tick, pulse tx_done and go to START if a frame is available, else IDLE.
- Hold register:
  - tx_ready = !hold_full.
  - A beat accepted while the engine is busy, or not loaded via bypass, fills the hold register.
  - The hold register empties when it is loaded into the engine.
- Only s_tick advances counters. A tick arriving on the load edge is not counted.

## Timing
- Reset values (asynchronous):
  - tx=1, tx_busy=0, tx_done=0, tx_ready=1.
  - State IDLE; all counters, the shift register and the hold register cleared.
- tx, tx_busy and tx_done are registered. tx reflects the current state with no combinational path from inputs.
- Acceptance in IDLE with hold empty: at the accepting edge, state becomes START, tx goes to 0 and tx_busy goes to 1.
- Frame length in s_tick pulses: OVS*(1+dbits+parity_en) + stop_ticks.
- Back-to-back: the first START tick count begins on the edge after the previous stop's final tick. tx_done pulses on that same edge. The line never returns to idle-high between the frames.
- Accept coinciding with the final stop tick and hold empty: the beat is bypass-loaded and tx_ready stays high.
- Hold full: tx_ready is low until the edge at which the held beat loads, and high from the next cycle.
- Reset asserted mid-frame aborts the frame immediately: tx=1, no tx_done, pending data discarded.
- s_tick while IDLE is ignored.

## Test plan
- 8N1, tx_data=0xA5, OVS=16, s_tick every 4 clocks -> tx bits 0,1,0,1,0,0,1,0,1,1, each 16 ticks; tx_busy high for exactly 160 ticks; one tx_done pulse.
- 7E1, tx_data=0xB5 -> data bits 1,0,1,0,1,1,0, parity 0, one stop; bit 7 of tx_data is never driven. Repeat 7O1 -> parity 1.
- 5O2, tx_data=0x1F -> five 1s, parity 0, stop high for 32 ticks; total 144 ticks.
- 8N1.5, tx_data=0x00 -> stop lasts 24 ticks; tx_done pulses after tick 168.
- Back-to-back, beats 0x55 then 0xAA offered continuously:
  - The second beat is accepted during frame 1 and tx_ready then stays low.
  - The start bit of 0xAA follows the stop bit of 0x55 with zero idle cycles.
  - tx_done pulses twice; tx_ready goes high after frame 2 loads.
- Reset pulse during DATA of 0x3C, with 0xC3 in hold -> tx=1, tx_busy=0, tx_ready=1 immediately. 0xC3 is never transmitted. A subsequent 0x81 frame is bit-exact.
